fx_bus_arb: RTL and testbench



---
 rtl/fx_bus_pkg.sv | 24 ++
 rtl/fx_bus_arb_rr_pick.sv | 41 ++++
 rtl/fx_bus_arb.sv | 187 ++++++++++++++++++
 tb/tb_fx_bus_arb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_bus_pkg.sv
// Shared definitions for fx register-bus masters: bus widths, arbiter
// state encoding and a width helper.
package fx_bus_pkg;

    localparam int FX_ADDR_W = 16;
    localparam int FX_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } fx_state_e;

    // Bits needed to hold values 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/fx_bus_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping to the lowest set request when none is found above.
module rr_pick
    import fx_bus_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] hi_req;
    logic [N-1:0] sel_vec;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign hi_mask[gi] = (IW'(gi) >= ptr);
        end
    endgenerate

    assign hi_req  = req & hi_mask;
    assign sel_vec = (|hi_req) ? hi_req : req;
    // Two's-complement trick isolates the lowest set bit.
    assign grant   = sel_vec & (~sel_vec + N'(1));
    assign any     = |req;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                idx = idx | IW'(i);
            end
        end
    end

endmodule

// File: rtl/fx_bus_arb.sv
// Round-robin arbiter and sequencer for the fx register bus: issues one
// write or read at a time and returns read data to the owning requester.
module fx_bus_arb
    import fx_bus_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int RD_LAT = 2,
    parameter int ADDR_W = FX_ADDR_W,
    parameter int DATA_W = FX_DATA_W
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_vld,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ack,
    output logic [NREQ-1:0]          rsp_vld,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [ADDR_W-1:0]        fx_waddr,
    output logic                     fx_wr,
    output logic [DATA_W-1:0]        fx_data,
    output logic                     fx_rd,
    output logic [ADDR_W-1:0]        fx_raddr,
    input  logic [DATA_W-1:0]        fx_q,
    output logic                     busy
);

    localparam int IW = clog2(NREQ);
    localparam int CW = clog2(RD_LAT + 2);

    logic [ADDR_W-1:0] addr_arr [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    fx_state_e         state_reg,    state_next;
    logic [IW-1:0]     ptr_reg,      ptr_next;
    logic [CW-1:0]     cnt_reg,      cnt_next;
    logic [IW-1:0]     idx_reg,      idx_next;
    logic              wr_reg,       wr_next;
    logic [DATA_W-1:0] cap_reg,      cap_next;
    logic [NREQ-1:0]   req_ack_reg,  req_ack_next;
    logic [NREQ-1:0]   rsp_vld_reg,  rsp_vld_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic [ADDR_W-1:0] fx_waddr_reg, fx_waddr_next;
    logic              fx_wr_reg,    fx_wr_next;
    logic [DATA_W-1:0] fx_data_reg,  fx_data_next;
    logic              fx_rd_reg,    fx_rd_next;
    logic [ADDR_W-1:0] fx_raddr_reg, fx_raddr_next;
    logic              busy_reg,     busy_next;

    logic [NREQ-1:0]   pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req   (req_vld),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            wr_reg       <= 1'b0;
            cap_reg      <= '0;
            req_ack_reg  <= '0;
            rsp_vld_reg  <= '0;
            rsp_data_reg <= '0;
            fx_waddr_reg <= '0;
            fx_wr_reg    <= 1'b0;
            fx_data_reg  <= '0;
            fx_rd_reg    <= 1'b0;
            fx_raddr_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            wr_reg       <= wr_next;
            cap_reg      <= cap_next;
            req_ack_reg  <= req_ack_next;
            rsp_vld_reg  <= rsp_vld_next;
            rsp_data_reg <= rsp_data_next;
            fx_waddr_reg <= fx_waddr_next;
            fx_wr_reg    <= fx_wr_next;
            fx_data_reg  <= fx_data_next;
            fx_rd_reg    <= fx_rd_next;
            fx_raddr_reg <= fx_raddr_next;
            busy_reg     <= busy_next;
        end
    end

    // Bus strobes are registered on the IDLE->ISSUE edge so they appear
    // exactly during the ISSUE cycle, together with the ack pulse.
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        wr_next       = wr_reg;
        cap_next      = cap_reg;
        rsp_data_next = rsp_data_reg;
        req_ack_next  = '0;
        rsp_vld_next  = '0;
        fx_waddr_next = '0;
        fx_wr_next    = 1'b0;
        fx_data_next  = '0;
        fx_rd_next    = 1'b0;
        fx_raddr_next = '0;

        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next   = ISSUE;
                    idx_next     = pick_idx;
                    wr_next      = req_wr[pick_idx];
                    req_ack_next = pick_grant;
                    if (req_wr[pick_idx]) begin
                        fx_wr_next    = 1'b1;
                        fx_waddr_next = addr_arr[pick_idx];
                        fx_data_next  = data_arr[pick_idx];
                    end else begin
                        fx_rd_next    = 1'b1;
                        fx_raddr_next = addr_arr[pick_idx];
                    end
                end
            end

            ISSUE: begin
                ptr_next = (idx_reg == IW'(NREQ - 1)) ? '0 : idx_reg + 1'b1;
                if (wr_reg) begin
                    state_next = IDLE;
                end else begin
                    state_next = RDWAIT;
                    cnt_next   = CW'(1);
                end
            end

            RDWAIT: begin
                if (cnt_reg == CW'(RD_LAT)) begin
                    cap_next = fx_q;
                    cnt_next = cnt_reg + 1'b1;
                end else if (cnt_reg == CW'(RD_LAT + 1)) begin
                    rsp_vld_next[idx_reg] = 1'b1;
                    rsp_data_next         = cap_reg;
                    cnt_next              = '0;
                    state_next            = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign req_ack  = req_ack_reg;
    assign rsp_vld  = rsp_vld_reg;
    assign rsp_data = rsp_data_reg;
    assign fx_waddr = fx_waddr_reg;
    assign fx_wr    = fx_wr_reg;
    assign fx_data  = fx_data_reg;
    assign fx_rd    = fx_rd_reg;
    assign fx_raddr = fx_raddr_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_fx_bus_arb.sv
// Directed bench for fx_bus_arb: one RD_LAT=2 instance and one RD_LAT=1
// instance sharing stimulus.
module tb_fx_bus_arb;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_vld = '0;
    logic [1:0]  req_wr = '0;
    logic [31:0] req_addr = '0;
    logic [15:0] req_data = '0;
    logic [7:0]  fx_q = '0;

    logic [1:0]  req_ack, rsp_vld;
    logic [7:0]  rsp_data, fx_data;
    logic [15:0] fx_waddr, fx_raddr;
    logic        fx_wr, fx_rd, busy;

    logic [1:0]  req_ack_l1, rsp_vld_l1;
    logic [7:0]  rsp_data_l1, fx_data_l1;
    logic [15:0] fx_waddr_l1, fx_raddr_l1;
    logic        fx_wr_l1, fx_rd_l1, busy_l1;

    logic [54:0] all0, all1;
    assign all0 = {req_ack, rsp_vld, rsp_data, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr, busy};
    assign all1 = {req_ack_l1, rsp_vld_l1, rsp_data_l1, fx_waddr_l1, fx_wr_l1, fx_data_l1,
                   fx_rd_l1, fx_raddr_l1, busy_l1};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    fx_bus_arb #(.NREQ(2), .RD_LAT(2), .ADDR_W(16), .DATA_W(8)) dut (
        .clk_sys(clk_sys), .rst(rst), .req_vld(req_vld), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data), .req_ack(req_ack),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data), .fx_waddr(fx_waddr),
        .fx_wr(fx_wr), .fx_data(fx_data), .fx_rd(fx_rd), .fx_raddr(fx_raddr),
        .fx_q(fx_q), .busy(busy)
    );

    fx_bus_arb #(.NREQ(2), .RD_LAT(1), .ADDR_W(16), .DATA_W(8)) dut_l1 (
        .clk_sys(clk_sys), .rst(rst), .req_vld(req_vld), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data), .req_ack(req_ack_l1),
        .rsp_vld(rsp_vld_l1), .rsp_data(rsp_data_l1), .fx_waddr(fx_waddr_l1),
        .fx_wr(fx_wr_l1), .fx_data(fx_data_l1), .fx_rd(fx_rd_l1), .fx_raddr(fx_raddr_l1),
        .fx_q(fx_q), .busy(busy_l1)
    );

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_vld = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_vld = '0;
        tick();
        tick();
        n_vec++;
        if (all0 !== 55'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h want 0", all0);
        end
        n_vec++;
        if (all1 !== 55'd0) begin
            n_err++; $display("FAIL reset_outputs_l1: got %h want 0", all1);
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs=%h", all0);
    endtask

    task automatic test_write;
        req_vld = 2'b01; req_wr = 2'b01;
        req_addr[15:0] = 16'h0312; req_data[7:0] = 8'hA5;
        tick();
        req_vld = '0;
        $display("write req0 addr=%h data=%h ack=%b", fx_waddr, fx_data, req_ack);
        n_vec++;
        if (fx_wr !== 1'b1) begin n_err++; $display("FAIL wr_strobe: got %b want 1", fx_wr); end
        n_vec++;
        if (fx_waddr !== 16'h0312) begin n_err++; $display("FAIL wr_addr: got %h want 0312", fx_waddr); end
        n_vec++;
        if (fx_data !== 8'hA5) begin n_err++; $display("FAIL wr_data: got %h want a5", fx_data); end
        n_vec++;
        if (req_ack !== 2'b01) begin n_err++; $display("FAIL wr_ack: got %b want 01", req_ack); end
        n_vec++;
        if ({fx_rd, fx_raddr} !== 17'd0) begin
            n_err++; $display("FAIL wr_rd_idle: got rd=%b raddr=%h want 0", fx_rd, fx_raddr);
        end
        tick();
        n_vec++;
        if ({fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, req_ack} !== 44'd0) begin
            n_err++; $display("FAIL wr_release: got wr=%b waddr=%h data=%h rd=%b ack=%b want 0",
                              fx_wr, fx_waddr, fx_data, fx_rd, req_ack);
        end
        tick();
    endtask

    task automatic test_read;
        req_vld = 2'b10; req_wr = 2'b00;
        req_addr[31:16] = 16'h0105;
        tick();
        req_vld = '0;
        fx_q = 8'hEE;
        $display("read req1 addr=%h ack=%b", fx_raddr, req_ack);
        n_vec++;
        if ({fx_rd, fx_raddr, req_ack, fx_wr} !== {1'b1, 16'h0105, 2'b10, 1'b0}) begin
            n_err++; $display("FAIL rd_issue: got rd=%b raddr=%h ack=%b wr=%b want 1 0105 10 0",
                              fx_rd, fx_raddr, req_ack, fx_wr);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            fx_q = (k == 2) ? 8'h3C : 8'hEE;
            n_vec++;
            if (rsp_vld !== ((k == 4) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL rd_rsp_vld[%0d]: got %b want %b", k, rsp_vld,
                                  (k == 4) ? 2'b10 : 2'b00);
            end
            n_vec++;
            if (busy !== (k <= 3)) begin
                n_err++; $display("FAIL rd_busy[%0d]: got %b want %b", k, busy, (k <= 3));
            end
            if (k >= 4) begin
                n_vec++;
                if (rsp_data !== 8'h3C) begin
                    n_err++; $display("FAIL rd_data[%0d]: got %h want 3c", k, rsp_data);
                end
            end
        end
        $display("read req1 done data=%h", rsp_data);
        fx_q = 8'h00;
    endtask

    task automatic test_round_robin;
        logic [1:0] want_ack;
        do_reset();
        req_vld = 2'b11; req_wr = 2'b11;
        req_addr = {16'h0020, 16'h0010}; req_data = {8'h22, 8'h11};
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 12) req_vld = '0;
            want_ack = (j % 2 == 1) ? (((j - 1) / 2) % 2 == 0 ? 2'b01 : 2'b10) : 2'b00;
            n_vec++;
            if (req_ack !== want_ack) begin
                n_err++; $display("FAIL rr_ack[%0d]: got %b want %b", j, req_ack, want_ack);
            end
            n_vec++;
            if (fx_wr !== (j % 2 == 1)) begin
                n_err++; $display("FAIL rr_strobe[%0d]: got %b want %b", j, fx_wr, (j % 2 == 1));
            end
            if (want_ack == 2'b10) begin
                n_vec++;
                if ({fx_waddr, fx_data} !== {16'h0020, 8'h22}) begin
                    n_err++; $display("FAIL rr_fields1[%0d]: got %h %h want 0020 22", j, fx_waddr, fx_data);
                end
            end
            if (want_ack != 2'b00) $display("rr write ack=%b addr=%h data=%h", req_ack, fx_waddr, fx_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_read;
        req_vld = 2'b01; req_wr = 2'b00; req_addr[15:0] = 16'h0777;
        tick();
        req_vld = '0;
        n_vec++;
        if ({fx_rd, req_ack} !== 3'b101) begin
            n_err++; $display("FAIL abort_issue: got rd=%b ack=%b want 1 01", fx_rd, req_ack);
        end
        tick();
        rst = 1'b1;
        fx_q = 8'h5A;
        tick();
        rst = 1'b0;
        $display("read req0 aborted by reset outputs=%h", all0);
        n_vec++;
        if (all0 !== 55'd0) begin n_err++; $display("FAIL abort_outputs: got %h want 0", all0); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if ({rsp_vld, busy} !== 3'b000) begin
                n_err++; $display("FAIL abort_quiet[%0d]: got rsp=%b busy=%b want 0", k, rsp_vld, busy);
            end
        end
        req_vld = 2'b11; req_wr = 2'b00; req_addr = {16'h0500, 16'h0400};
        tick();
        req_vld = 2'b10;
        fx_q = 8'hEE;
        $display("read req0 after reset ack=%b addr=%h", req_ack, fx_raddr);
        n_vec++;
        if ({req_ack, fx_raddr} !== {2'b01, 16'h0400}) begin
            n_err++; $display("FAIL post_rst_grant: got ack=%b raddr=%h want 01 0400", req_ack, fx_raddr);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            fx_q = (k == 2) ? 8'h81 : 8'hEE;
            if (k == 4) begin
                n_vec++;
                if ({rsp_vld, rsp_data} !== {2'b01, 8'h81}) begin
                    n_err++; $display("FAIL post_rst_rsp: got %b %h want 01 81", rsp_vld, rsp_data);
                end
            end
            if (k == 5) begin
                req_vld = '0;
                $display("read req1 ack=%b addr=%h", req_ack, fx_raddr);
                n_vec++;
                if ({req_ack, fx_rd, fx_raddr} !== {2'b10, 1'b1, 16'h0500}) begin
                    n_err++; $display("FAIL post_rst_next: got ack=%b rd=%b raddr=%h want 10 1 0500",
                                      req_ack, fx_rd, fx_raddr);
                end
            end
        end
        for (int k = 0; k < 5; k++) tick();
    endtask

    task automatic test_rd_lat1;
        do_reset();
        req_vld = 2'b01; req_wr = 2'b00; req_addr[15:0] = 16'h0042;
        tick();
        req_vld = '0;
        fx_q = 8'h22;
        n_vec++;
        if ({fx_rd_l1, req_ack_l1} !== 3'b101) begin
            n_err++; $display("FAIL l1_issue: got rd=%b ack=%b want 1 01", fx_rd_l1, req_ack_l1);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            fx_q = (k == 1) ? 8'hFF : (k == 2) ? 8'h11 : 8'h22;
            n_vec++;
            if (rsp_vld_l1 !== ((k == 3) ? 2'b01 : 2'b00)) begin
                n_err++; $display("FAIL l1_rsp_vld[%0d]: got %b want %b", k, rsp_vld_l1,
                                  (k == 3) ? 2'b01 : 2'b00);
            end
            if (k >= 3) begin
                n_vec++;
                if (rsp_data_l1 !== 8'hFF) begin
                    n_err++; $display("FAIL l1_rsp_data[%0d]: got %h want ff", k, rsp_data_l1);
                end
            end
            if (k == 4) begin
                n_vec++;
                if ({rsp_vld, rsp_data} !== {2'b01, 8'h11}) begin
                    n_err++; $display("FAIL l2_rsp_cmp: got %b %h want 01 11", rsp_vld, rsp_data);
                end
            end
        end
        $display("read req0 lat1 data=%h lat2 data=%h", rsp_data_l1, rsp_data);
        fx_q = 8'h00;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_reset_mid_read();
        test_rd_lat1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
